// File: rtl/spi_pkg.sv
// Shared types and constants for the byte-wide SPI master.
// Register offsets, control bit positions and FSM states.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } spi_state_e;

  localparam logic RS_CTRL = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int CTRL_CS0  = 0;
  localparam int CTRL_CS1  = 1;
  localparam int CTRL_WCS  = 2;
  localparam int CTRL_FAST = 3;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_clkdiv.sv
// Loadable down-counter for the SPI half-period.
// expire is high while the count sits at zero.
module spi_clkdiv #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 MSB-first byte SPI master behind the CPU register window.
// SEL_n is synchronised; each falling edge yields one register access.
module spi_master
  import spi_pkg::*;
#(
  parameter int SLOW_DIV = 64,
  parameter int FAST_DIV = 2
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       SEL_n,
  input  logic       RS,
  input  logic       RW,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       BUSY,
  output logic       SPI_CLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic [1:0] SPI_CS,
  output logic       SPI_WCS
);

  localparam int W = $clog2(SLOW_DIV);
  localparam logic [W-1:0] SLOW_LD = W'(SLOW_DIV - 1);
  localparam logic [W-1:0] FAST_LD = W'(FAST_DIV - 1);

  logic       sel_s1, sel_s2, sel_s3;
  logic       access, start, ctrl_wr;
  logic [7:0] tx_byte;
  logic [3:0] ctrl_q;
  logic [7:0] do_q;

  spi_state_e state_q, state_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       miso_q, miso_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] rx_q, rx_d;
  logic       fast_q, fast_d;
  logic       load, expire;
  logic [W-1:0] load_val;

  assign access  = sel_s3 & ~sel_s2;
  assign start   = access && (RS == RS_DATA) && (state_q == IDLE);
  assign ctrl_wr = access && (RS == RS_CTRL) && !RW;
  assign tx_byte = RW ? IDLE_BYTE : DI;

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      sel_s1 <= 1'b1;
      sel_s2 <= 1'b1;
      sel_s3 <= 1'b1;
      ctrl_q <= '0;
      do_q   <= IDLE_BYTE;
    end else begin
      sel_s1 <= SEL_n;
      sel_s2 <= sel_s1;
      sel_s3 <= sel_s2;
      if (ctrl_wr) ctrl_q <= DI[3:0];
      do_q <= (RS == RS_DATA) ? rx_q :
        {BUSY, 3'b000, ctrl_q[CTRL_FAST], ctrl_q[CTRL_WCS],
         ctrl_q[CTRL_CS1], ctrl_q[CTRL_CS0]};
    end
  end

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      miso_q  <= 1'b0;
      shift_q <= '0;
      bit_q   <= '0;
      rx_q    <= IDLE_BYTE;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      miso_q  <= miso_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      fast_q  <= fast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    miso_d  = miso_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    fast_d  = fast_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOW;
          shift_d = tx_byte;
          mosi_d  = tx_byte[7];
          bit_d   = 3'd7;
          fast_d  = ctrl_q[CTRL_FAST];
          load    = 1'b1;
        end
      end
      LOW: begin
        if (expire) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          miso_d  = SPI_MISO;
          load    = 1'b1;
        end
      end
      HIGH: begin
        if (expire) begin
          sclk_d = 1'b0;
          load   = 1'b1;
          if (bit_q != 3'd0) begin
            state_d = LOW;
            shift_d = {shift_q[6:0], miso_q};
            mosi_d  = shift_q[6];
            bit_d   = bit_q - 3'd1;
          end else begin
            state_d = IDLE;
            rx_d    = {shift_q[6:0], miso_q};
            mosi_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Half-period follows the mode captured at start, not the live bit.
  assign load_val = fast_d ? FAST_LD : SLOW_LD;

  spi_clkdiv #(.W(W)) u_div (
    .clk      (CLKCPU),
    .rst_n    (RESET),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  assign BUSY     = (state_q != IDLE);
  assign SPI_CLK  = sclk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS   = ~ctrl_q[CTRL_CS1:CTRL_CS0];
  assign SPI_WCS  = ~ctrl_q[CTRL_WCS];
  assign DO       = do_q;

endmodule

// File: doc/spi_master.md
# spi_master

Byte-wide SPI master behind the accelerator's CPU-side register window. It is the engine that produces the SD/flash card signals. The bus-decode top level (autoconfig hit, `DS20` qualification) supplies a select strobe, register select, direction and write data. This block runs a mode-0, MSB-first 8-bit transfer on `SPI_CLK`, `SPI_MOSI` and `SPI_MISO`, and returns received data and status for the top level's read-data mux.

## Interface
- `SLOW_DIV`, 64: CPU clocks per SPI half-period in slow (card-init) mode; ≥2.
- `FAST_DIV`, 2: CPU clocks per SPI half-period in fast mode; ≥1.
- `CLKCPU` in 1: sole clock. All state changes on its rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `SEL_n` in 1: register select, active low. Asynchronous to `CLKCPU`; synchronised internally.
- `RS` in 1: register select. 0 = control/status, 1 = data.
- `RW` in 1: 1 = read, 0 = write. Sampled with `RS`/`DI` at access detection.
- `DI` in 8: write data (CPU `D[15:8]`).
- `DO` out 8: read data, valid while `SEL_n` low. RS=0: status. RS=1: receive register.
- `BUSY` out 1: transfer in progress.
- `SPI_CLK` out 1: serial clock. Idles low.
- `SPI_MOSI` out 1: serial out. Idles high.
- `SPI_MISO` in 1: serial in.
- `SPI_CS` out 2: card selects, active low.
- `SPI_WCS` out 1: flash select, active low.

## Operation
- **Access detection**
  - `SEL_n` passes through a 2-flop synchroniser.
  - One access fires on the first cycle the synchronised `SEL_n` is low after being high.
  - Holding `SEL_n` low never retriggers.
- **Control write (RS=0)**
  - `DI[0]` asserts `SPI_CS[0]`, `DI[1]` asserts `SPI_CS[1]`, `DI[2]` asserts `SPI_WCS`. A 1 drives the pin low.
  - `DI[3]` = fast mode.
  - Takes effect the cycle after detection, even while busy.
- **Status read (RS=0)**
  - `DO = {BUSY, 3'b000, fast, ~SPI_WCS, ~SPI_CS[1], ~SPI_CS[0]}`.
- **Data write (RS=1, RW=0)**
  - When idle: loads `DI` into the shift register and starts a transfer.
  - When busy: ignored.
- **Data read (RS=1, RW=1)**
  - `DO` = receive register.
  - When idle: also starts a transfer sending 0xFF (read-triggered clocking).
  - When busy: returns the stale byte and starts nothing.
- **FSM**
  - IDLE → LOW: on start. `SPI_MOSI` = bit 7, bit counter = 7, divider loaded.
  - LOW → HIGH: on divider expiry. `SPI_CLK` rises; `SPI_MISO` is sampled into the shift LSB.
  - HIGH → LOW: on divider expiry with count ≠ 0. `SPI_CLK` falls; shift left; `SPI_MOSI` takes the next bit; count decrements.
  - HIGH → IDLE: on expiry with count = 0. `SPI_CLK` falls; receive register takes the shifted byte; `SPI_MOSI` returns to 1.
- **Divider**
  - Width is `$clog2(SLOW_DIV)`.
  - The mode is latched at transfer start. Toggling fast mode mid-transfer affects only the next transfer.

## Timing
- **Reset values**
  - `SPI_CLK` = 0, `SPI_MOSI` = 1, `SPI_CS` = 2'b11, `SPI_WCS` = 1.
  - `BUSY` = 0, fast = 0, receive register = 0xFF, `DO` = 0xFF, FSM = IDLE.
- **Start latency:** `BUSY` and the first `SPI_MOSI` bit appear 3 cycles after `SEL_n` falls (2 sync + 1 detect).
- **Transfer length:** 16×DIV cycles from start to IDLE, with DIV = `SLOW_DIV` or `FAST_DIV`.
  - The receive register updates and `BUSY` drops in the same cycle as the final `SPI_CLK` fall.
- **SPI mode 0**
  - `SPI_MOSI` is stable ≥ DIV cycles before each rising edge.
  - `SPI_MISO` is sampled on the `CLKCPU` edge that raises `SPI_CLK`.
- **`DO`** is registered and updates each cycle. It is valid 2 cycles after `RS` is stable.
- **Reset mid-transfer** aborts immediately to the reset values. No partial byte reaches the receive register.
- **Simultaneous events**
  - A control write during a transfer changes CS mid-byte. This is software's responsibility; the hardware does not block it.
  - A start request in the same cycle `BUSY` drops is ignored, because detection sees BUSY = 1.

## Structure
- Package `spi_pkg`:
  - FSM state enum: `IDLE`, `LOW`, `HIGH`.
  - Register offsets: `RS_CTRL` = 0, `RS_DATA` = 1.
  - Control bit indices.
  - Idle byte 8'hFF.
- One sub-module, `spi_clkdiv`: loadable down-counter with expiry pulse, parameterised by width. The main module holds the synchroniser, registers and FSM.

## Test plan
1. Reset low mid-transfer, then release → all outputs at the reset values; `DO` reads 0xFF at RS=1.
2. Control write 0x01, then data write 0xA5 with slow mode and MISO looped to MOSI → `SPI_CS` = 2'b10; 8 `SPI_CLK` pulses each 128 cycles; MOSI pattern 1,0,1,0,0,1,0,1; `BUSY` high for 1024 cycles; RS=1 read returns 0xA5.
3. Control write 0x08, then data read with MISO tied 0 → 8 pulses of 4 cycles each; MOSI held 1; receive register = 0x00 after 32 cycles.
4. Data write 0x3C during a busy transfer of 0x55 → write ignored; completes as 0x55 only; exactly 8 clocks.
5. `SEL_n` held low 500 cycles on a data read → exactly one transfer starts.
6. Control write 0x08 mid slow-transfer → current byte keeps the 64-cycle half-period; the next transfer uses 2.
